// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with majority vote, optional parity and stop check
module uart_rx #(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             RX_IN,
    input  logic [5:0]       Prescale,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic [width-1:0] P_DATA,
    output logic             Data_valid,
    output logic             Par_err,
    output logic             Stop_err
);

    localparam int BW = (width > 1) ? $clog2(width) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]       samples_q, samples_d;
    logic [width-1:0] sr_q, sr_d;
    logic [5:0]       prescale_q, prescale_d;
    logic             par_en_q, par_en_d;
    logic             par_typ_q, par_typ_d;
    logic             par_fail_q, par_fail_d;
    logic             seen_high_q, seen_high_d;
    logic [width-1:0] p_data_q, p_data_d;
    logic             data_valid_q, data_valid_d;
    logic             par_err_q, par_err_d;
    logic             stop_err_q, stop_err_d;

    logic [5:0] half;
    logic       smp_slot;
    logic       dec_slot;
    logic       last_slot;
    logic       vote;
    logic       par_exp;

    assign half      = {1'b0, prescale_q[5:1]};
    assign smp_slot  = (state_q != S_IDLE) &&
                       ((edge_cnt_q == half - 6'd1) || (edge_cnt_q == half) ||
                        (edge_cnt_q == half + 6'd1));
    assign dec_slot  = (edge_cnt_q == half + 6'd2);
    assign last_slot = (edge_cnt_q == prescale_q - 6'd1);
    assign vote      = (samples_q[0] & samples_q[1]) | (samples_q[0] & samples_q[2]) |
                       (samples_q[1] & samples_q[2]);
    assign par_exp   = par_typ_q ? ~^sr_q : ^sr_q;

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        samples_d    = samples_q;
        sr_d         = sr_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_fail_d   = par_fail_q;
        seen_high_d  = seen_high_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stop_err_d   = 1'b0;

        if (state_q != S_IDLE) begin
            edge_cnt_d = last_slot ? 6'd0 : edge_cnt_q + 6'd1;
        end
        if (smp_slot) begin
            samples_d = {samples_q[1:0], RX_IN};
        end

        case (state_q)
            S_IDLE: begin
                // A continuous low (break) must not retrigger: require a high first.
                if (RX_IN) begin
                    seen_high_d = 1'b1;
                end else if (seen_high_q) begin
                    state_d     = S_START;
                    edge_cnt_d  = 6'd1;
                    bit_cnt_d   = '0;
                    prescale_d  = Prescale;
                    par_en_d    = PAR_EN;
                    par_typ_d   = PAR_TYP;
                    par_fail_d  = 1'b0;
                    seen_high_d = 1'b0;
                end
            end
            S_START: begin
                if (dec_slot && vote) begin
                    state_d     = S_IDLE;
                    edge_cnt_d  = 6'd0;
                    seen_high_d = 1'b1;
                end else if (last_slot) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (dec_slot) begin
                    sr_d = {vote, sr_q[width-1:1]};
                end
                if (last_slot) begin
                    if (bit_cnt_q == BW'(width - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (dec_slot && (vote != par_exp)) begin
                    par_fail_d = 1'b1;
                end
                if (last_slot) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (last_slot) begin
                    state_d     = S_IDLE;
                    stop_err_d  = ~vote;
                    par_err_d   = par_fail_q;
                    seen_high_d = vote;
                    if (vote && !par_fail_q) begin
                        p_data_d     = sr_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            samples_q    <= '0;
            sr_q         <= '0;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_fail_q   <= 1'b0;
            seen_high_q  <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samples_q    <= samples_d;
            sr_q         <= sr_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_fail_q   <= par_fail_d;
            seen_high_q  <= seen_high_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stop_err_q   <= stop_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_valid = data_valid_q;
    assign Par_err    = par_err_q;
    assign Stop_err   = stop_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed vector bench for uart_rx
module tb_uart_rx;

    logic       CLK;
    logic       Reset;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_valid;
    logic       Par_err;
    logic       Stop_err;

    uart_rx #(.width(8)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_valid (Data_valid),
        .Par_err    (Par_err),
        .Stop_err   (Stop_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    int         n_dv = 0;
    int         n_pe = 0;
    int         n_se = 0;
    int         pulse_cyc = 0;
    logic [7:0] pd_q[$];
    always @(negedge CLK) begin
        if (Data_valid) begin
            n_dv = n_dv + 1;
            pd_q.push_back(P_DATA);
        end
        if (Par_err)  n_pe = n_pe + 1;
        if (Stop_err) n_se = n_se + 1;
        if (Data_valid || Par_err || Stop_err) pulse_cyc = cyc;
    end

    typedef struct {
        int         pre;
        logic       pen;
        logic       ptyp;
        logic [7:0] data;
        logic       pbit;
        logic       sbit;
        int         gbit;
        int         gslot;
        int         exp_dv;
        int         exp_pe;
        int         exp_se;
        logic [7:0] exp_pd;
        int         exp_edge;
    } vec_t;

    vec_t vecs[8];

    int n_vec = 0;
    int n_err = 0;
    int start_cyc = 0;
    int b_dv, b_pe, b_se;

    task automatic chk(input string name, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic logic fbit(input int b, input logic [7:0] d, input logic pen,
                                  input logic pb, input logic sb);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pen && b == 9) return pb;
        return sb;
    endfunction

    // Drives up to max_bits bits of a frame; one inverted cycle at (gbit, gslot).
    task automatic send_frame(input int pre, input logic pen, input logic ptyp,
                              input logic [7:0] d, input logic pb, input logic sb,
                              input int gbit, input int gslot, input int max_bits);
        int   nb;
        logic v;
        nb = pen ? 11 : 10;
        if (max_bits < nb) nb = max_bits;
        Prescale  = 6'(pre);
        PAR_EN    = pen;
        PAR_TYP   = ptyp;
        start_cyc = cyc;
        for (int b = 0; b < nb; b++) begin
            v = fbit(b, d, pen, pb, sb);
            for (int j = 0; j < pre; j++) begin
                RX_IN = ((b == gbit) && (j == gslot)) ? ~v : v;
                tick(1);
            end
        end
        RX_IN = 1'b1;
    endtask

    task automatic snap();
        b_dv = n_dv;
        b_pe = n_pe;
        b_se = n_se;
    endtask

    initial begin
        vecs[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1, 0, 1, 0, 0, 8'hA5, 79};
        vecs[1] = '{16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, -1, 0, 1, 0, 0, 8'h3C, 175};
        vecs[2] = '{16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, -1, 0, 0, 1, 0, 8'h3C, 175};
        vecs[3] = '{32, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, -1, 0, 0, 0, 1, 8'h3C, 351};
        vecs[4] = '{8,  1'b1, 1'b1, 8'h00, 1'b0, 1'b0, -1, 0, 0, 1, 1, 8'h3C, 87};
        vecs[5] = '{16, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 2,  8, 1, 0, 0, 8'h5A, 159};
        vecs[6] = '{32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, -1, 0, 1, 0, 0, 8'h81, 319};
        vecs[7] = '{8,  1'b1, 1'b0, 8'h01, 1'b1, 1'b1, -1, 0, 1, 0, 0, 8'h01, 87};

        Reset = 1'b0; RX_IN = 1'b1; Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        tick(3);
        chk("reset_pdata", int'(P_DATA), 0);
        chk("reset_valid", int'(Data_valid), 0);
        chk("reset_perr", int'(Par_err), 0);
        chk("reset_serr", int'(Stop_err), 0);
        Reset = 1'b1;
        tick(4);

        // Start-bit glitch: 3 low cycles then high.
        snap();
        Prescale = 6'd16;
        RX_IN = 1'b0;
        tick(3);
        RX_IN = 1'b1;
        tick(40);
        chk("glitch_pulses", (n_dv - b_dv) + (n_pe - b_pe) + (n_se - b_se), 0);

        for (int i = 0; i < 8; i++) begin
            snap();
            send_frame(vecs[i].pre, vecs[i].pen, vecs[i].ptyp, vecs[i].data,
                       vecs[i].pbit, vecs[i].sbit, vecs[i].gbit, vecs[i].gslot, 99);
            tick(4);
            chk($sformatf("v%0d_dv", i), n_dv - b_dv, vecs[i].exp_dv);
            chk($sformatf("v%0d_pe", i), n_pe - b_pe, vecs[i].exp_pe);
            chk($sformatf("v%0d_se", i), n_se - b_se, vecs[i].exp_se);
            chk($sformatf("v%0d_pdata", i), int'(P_DATA), int'(vecs[i].exp_pd));
            chk($sformatf("v%0d_edge", i), pulse_cyc - start_cyc - 1, vecs[i].exp_edge);
        end

        // Break: line low for longer than a frame.
        snap();
        Prescale = 6'd8; PAR_EN = 1'b0;
        start_cyc = cyc;
        RX_IN = 1'b0;
        tick(100);
        RX_IN = 1'b1;
        tick(4);
        chk("break_dv", n_dv - b_dv, 0);
        chk("break_se", n_se - b_se, 1);
        chk("break_pe", n_pe - b_pe, 0);
        chk("break_pdata", int'(P_DATA), 8'h01);
        chk("break_edge", pulse_cyc - start_cyc - 1, 79);

        // Back-to-back frames with no idle gap.
        snap();
        send_frame(8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, -1, 0, 99);
        send_frame(8, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, -1, 0, 99);
        tick(4);
        chk("b2b_dv", n_dv - b_dv, 2);
        chk("b2b_err", (n_pe - b_pe) + (n_se - b_se), 0);
        if (pd_q.size() >= 2) begin
            chk("b2b_first", int'(pd_q[pd_q.size()-2]), 8'h55);
            chk("b2b_second", int'(pd_q[pd_q.size()-1]), 8'hAA);
        end else begin
            chk("b2b_queue", pd_q.size(), 2);
        end
        chk("b2b_edge", pulse_cyc - start_cyc - 1, 79);

        // Reset during the data bits of 0x12, then a clean 0x34.
        snap();
        send_frame(8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, -1, 0, 4);
        Reset = 1'b0;
        #1;
        chk("rst_mid_pdata", int'(P_DATA), 0);
        chk("rst_mid_valid", int'(Data_valid), 0);
        chk("rst_mid_perr", int'(Par_err), 0);
        chk("rst_mid_serr", int'(Stop_err), 0);
        tick(3);
        Reset = 1'b1;
        tick(3);
        send_frame(8, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1, -1, 0, 99);
        tick(4);
        chk("post_rst_dv", n_dv - b_dv, 1);
        chk("post_rst_err", (n_pe - b_pe) + (n_se - b_se), 0);
        chk("post_rst_pdata", int'(P_DATA), 8'h34);
        chk("post_rst_edge", pulse_cyc - start_cyc - 1, 79);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side counterpart of the UART transmit path.
- Oversamples the asynchronous serial line RX_IN at Prescale× the bit rate.
- Detects a start bit, majority-votes each bit, deserializes LSB-first data, and checks optional parity and the stop bit.
- Presents the parallel word with a one-cycle valid pulse to the downstream register/FIFO logic.

Parameters:
- width, 8, number of data bits per frame (LSB transmitted first).

Ports:
- CLK  input  1  oversampling clock, Prescale × baud rate.
- Reset  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line; idle high; already synchronized to CLK upstream.
- Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
- PAR_EN  input  1  1 = frame contains a parity bit after the data.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  width  last correctly received word.
- Data_valid  output  1  one-cycle pulse; P_DATA updated this cycle.
- Par_err  output  1  one-cycle pulse; parity mismatch in the frame just ended.
- Stop_err  output  1  one-cycle pulse; stop bit sampled 0 in the frame just ended.

Behaviour:
- Reset (async, Reset=0): state=IDLE, counters=0, shift register=0, P_DATA=0, Data_valid=0, Par_err=0, Stop_err=0. Reset mid-frame abandons the frame; no pulses are generated.
- Frame format: start (0), width data bits LSB-first, optional parity bit, one stop bit (1). N = width+2, or width+3 if PAR_EN=1.
- Counters:
  - edge_cnt counts 0..Prescale-1 within a bit.
  - bit_cnt counts bits within the current state.
  - Prescale, PAR_EN and PAR_TYP are latched on start detection and held for the whole frame.
- Sampling:
  - Three samples taken at edge_cnt = Prescale/2-1, Prescale/2, Prescale/2+1.
  - Bit value = majority of the three samples.
  - Decision is available when edge_cnt = Prescale/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on RX_IN=0 → START with edge_cnt=1. The detection cycle counts as sample slot 0.
- START:
  - If the voted start bit = 1 (glitch) → IDLE immediately at the decision point, with no outputs.
  - Otherwise, at edge_cnt=Prescale-1 → DATA.
- DATA:
  - Voted bit shifted in MSB-side ({bit, sr[width-1:1]}), so the first received bit ends up in bit 0.
  - After width bits, at edge_cnt=Prescale-1 → PARITY if PAR_EN, else STOP.
- PARITY:
  - Expected bit = ^sr when PAR_TYP=0; ~^sr when PAR_TYP=1.
  - A mismatch sets an internal par_fail flag.
  - At edge_cnt=Prescale-1 → STOP.
- STOP: at edge_cnt=Prescale-1, evaluate and emit, then → IDLE:
  - voted stop bit = 0 → Stop_err=1 for one cycle;
  - par_fail → Par_err=1 for one cycle;
  - neither error → P_DATA<=sr and Data_valid=1 for one cycle.
  - Both errors may pulse in the same cycle.
  - On any error, P_DATA holds its previous value.
- Latency: outputs are registered on the edge numbered N×Prescale−1, counting the edge that first samples RX_IN=0 as edge 0.
- Back-to-back frames: a start bit immediately following a stop bit is detected from IDLE in the next cycle. A one-cycle phase offset is tolerated.
- RX_IN held low (break): produces a frame of 0x00 plus Stop_err. The FSM then waits in IDLE and restarts on the next sampled low after the line returns high.
  - IDLE does not re-trigger on the same continuous low: detection requires a prior 1 seen in IDLE.
- Illegal Prescale values: behaviour is undefined; no protection logic is required.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 (bits 1,0,1,0,0,1,0,1 on the line) → P_DATA=0xA5, Data_valid single pulse on edge 79, no error pulses.
- Prescale=16, PAR_EN=1, PAR_TYP=0, data 0x3C, parity 0 → P_DATA=0x3C, Data_valid on edge 175. Repeat with parity bit 1 → Par_err pulse, Data_valid=0, P_DATA stays 0x3C.
- Prescale=32, PAR_EN=1, PAR_TYP=1, data 0xFF, stop bit driven 0 → Stop_err=1 on edge 351. Parity bit 1 is correct for odd parity, so Par_err=0 and P_DATA is unchanged.
- Prescale=16, RX_IN low for 3 cycles then high → returns to IDLE, no pulses. Single-cycle glitch at sample slot Prescale/2 inside a data bit → majority vote yields the correct bit value.
- Two back-to-back 0x55/0xAA frames at Prescale=8 → two Data_valid pulses, P_DATA=0x55 then 0xAA.
- Reset asserted during DATA of frame 0x12 → all outputs 0 immediately. The next clean frame 0x34 → Data_valid with P_DATA=0x34.
